// File: rtl/sdram_ch2_bridge.sv
// 32-bit big-endian CPU access to 16-bit SDRAM ch2 port adapter.
// Splits writes into hi/lo word phases, runs the ardy/drdy handshake and guards it with a watchdog.
module sdram_ch2_bridge #(
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [19:0] cpu_addr,
    input  logic [3:0]  cpu_be,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_ack,
    output logic        cpu_busy,
    output logic        cpu_err,
    output logic [20:0] ch2addr,
    output logic [15:0] ch2din,
    output logic [1:0]  ch2wr,
    output logic        ch2rd,
    input  logic [31:0] ch2dout,
    input  logic        ch2ardy,
    input  logic        ch2drdy
);

    typedef enum logic [2:0] {
        IDLE,
        WR_HI,
        WR_LO,
        RD_REQ,
        RD_WAIT,
        DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [19:0]   addr_reg, addr_next;
    logic [3:0]    be_reg, be_next;
    logic [31:0]   din_reg, din_next;
    logic [TW-1:0] wd_reg, wd_next;
    logic          err_flag_reg, err_flag_next;
    logic          ardy_q, drdy_q;

    logic [31:0]   cpu_dout_reg, cpu_dout_next;
    logic          cpu_ack_reg, cpu_ack_next;
    logic          cpu_busy_reg, cpu_busy_next;
    logic          cpu_err_reg, cpu_err_next;
    logic [20:0]   ch2addr_reg, ch2addr_next;
    logic [15:0]   ch2din_reg, ch2din_next;
    logic [1:0]    ch2wr_reg, ch2wr_next;
    logic          ch2rd_reg, ch2rd_next;

    logic          ardy_rise, drdy_rise, wd_expired;

    assign ardy_rise  = ch2ardy & ~ardy_q;
    assign drdy_rise  = ch2drdy & ~drdy_q;
    // A wait state lasts at most TIMEOUT cycles: entry cycle holds 0, last one TIMEOUT-1.
    assign wd_expired = (wd_reg == TW'(TIMEOUT - 1));

    assign cpu_dout = cpu_dout_reg;
    assign cpu_ack  = cpu_ack_reg;
    assign cpu_busy = cpu_busy_reg;
    assign cpu_err  = cpu_err_reg;
    assign ch2addr  = ch2addr_reg;
    assign ch2din   = ch2din_reg;
    assign ch2wr    = ch2wr_reg;
    assign ch2rd    = ch2rd_reg;

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        be_next       = be_reg;
        din_next      = din_reg;
        wd_next       = '0;
        err_flag_next = err_flag_reg;
        cpu_dout_next = cpu_dout_reg;
        cpu_ack_next  = 1'b0;
        cpu_busy_next = cpu_busy_reg;
        cpu_err_next  = 1'b0;
        ch2addr_next  = ch2addr_reg;
        ch2din_next   = ch2din_reg;
        ch2wr_next    = ch2wr_reg;
        ch2rd_next    = ch2rd_reg;

        case (state_reg)
            IDLE: begin
                // busy stays up for the ack cycle, so the first idle cycle only drops it
                if (cpu_busy_reg) begin
                    cpu_busy_next = 1'b0;
                end else if (cpu_req) begin
                    addr_next     = cpu_addr;
                    be_next       = cpu_be;
                    din_next      = cpu_din;
                    cpu_busy_next = 1'b1;
                    err_flag_next = 1'b0;
                    if (cpu_we) begin
                        if (|cpu_be[3:2]) begin
                            state_next   = WR_HI;
                            ch2addr_next = {cpu_addr, 1'b0};
                            ch2din_next  = cpu_din[31:16];
                            ch2wr_next   = cpu_be[3:2];
                        end else if (|cpu_be[1:0]) begin
                            state_next   = WR_LO;
                            ch2addr_next = {cpu_addr, 1'b1};
                            ch2din_next  = cpu_din[15:0];
                            ch2wr_next   = cpu_be[1:0];
                        end else begin
                            state_next = DONE;
                        end
                    end else begin
                        state_next   = RD_REQ;
                        ch2addr_next = {cpu_addr, 1'b0};
                        ch2rd_next   = 1'b1;
                    end
                end
            end

            WR_HI: begin
                wd_next = wd_reg + TW'(1);
                if (ardy_rise) begin
                    ch2wr_next = 2'b00;
                    if (|be_reg[1:0]) begin
                        // strobes stay low for one cycle so the controller sees a fresh request
                        state_next   = WR_LO;
                        ch2addr_next = {addr_reg, 1'b1};
                        ch2din_next  = din_reg[15:0];
                    end else begin
                        state_next = DONE;
                    end
                end else if (wd_expired) begin
                    ch2wr_next    = 2'b00;
                    err_flag_next = 1'b1;
                    state_next    = DONE;
                end else begin
                    ch2addr_next = {addr_reg, 1'b0};
                    ch2din_next  = din_reg[31:16];
                    ch2wr_next   = be_reg[3:2];
                end
            end

            WR_LO: begin
                wd_next = wd_reg + TW'(1);
                if (ardy_rise) begin
                    ch2wr_next = 2'b00;
                    state_next = DONE;
                end else if (wd_expired) begin
                    ch2wr_next    = 2'b00;
                    err_flag_next = 1'b1;
                    state_next    = DONE;
                end else begin
                    ch2addr_next = {addr_reg, 1'b1};
                    ch2din_next  = din_reg[15:0];
                    ch2wr_next   = be_reg[1:0];
                end
            end

            RD_REQ: begin
                wd_next = wd_reg + TW'(1);
                if (ardy_rise) begin
                    ch2rd_next = 1'b0;
                    state_next = RD_WAIT;
                end else if (wd_expired) begin
                    ch2rd_next    = 1'b0;
                    err_flag_next = 1'b1;
                    state_next    = DONE;
                end else begin
                    ch2addr_next = {addr_reg, 1'b0};
                    ch2rd_next   = 1'b1;
                end
            end

            RD_WAIT: begin
                wd_next = wd_reg + TW'(1);
                if (drdy_rise) begin
                    cpu_dout_next = ch2dout;
                    state_next    = DONE;
                end else if (wd_expired) begin
                    err_flag_next = 1'b1;
                    state_next    = DONE;
                end
            end

            DONE: begin
                cpu_ack_next = 1'b1;
                cpu_err_next = err_flag_reg;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
                ch2wr_next = 2'b00;
                ch2rd_next = 1'b0;
            end
        endcase

        if (state_next != state_reg) begin
            wd_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            be_reg       <= '0;
            din_reg      <= '0;
            wd_reg       <= '0;
            err_flag_reg <= 1'b0;
            cpu_dout_reg <= '0;
            cpu_ack_reg  <= 1'b0;
            cpu_busy_reg <= 1'b0;
            cpu_err_reg  <= 1'b0;
            ch2addr_reg  <= '0;
            ch2din_reg   <= '0;
            ch2wr_reg    <= 2'b00;
            ch2rd_reg    <= 1'b0;
            // held high so a level already present at reset release is not an edge
            ardy_q       <= 1'b1;
            drdy_q       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            be_reg       <= be_next;
            din_reg      <= din_next;
            wd_reg       <= wd_next;
            err_flag_reg <= err_flag_next;
            cpu_dout_reg <= cpu_dout_next;
            cpu_ack_reg  <= cpu_ack_next;
            cpu_busy_reg <= cpu_busy_next;
            cpu_err_reg  <= cpu_err_next;
            ch2addr_reg  <= ch2addr_next;
            ch2din_reg   <= ch2din_next;
            ch2wr_reg    <= ch2wr_next;
            ch2rd_reg    <= ch2rd_next;
            ardy_q       <= ch2ardy;
            drdy_q       <= ch2drdy;
        end
    end

endmodule

// File: tb/tb_sdram_ch2_bridge.sv
// Directed bench for sdram_ch2_bridge: handshake driven by hand, expected values hand-computed.
module tb_sdram_ch2_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [19:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        cpu_ack;
    logic        cpu_busy;
    logic        cpu_err;
    logic [20:0] ch2addr;
    logic [15:0] ch2din;
    logic [1:0]  ch2wr;
    logic        ch2rd;
    logic [31:0] ch2dout;
    logic        ch2ardy;
    logic        ch2drdy;

    int checks = 0;
    int errors = 0;
    int ack_seen;

    sdram_ch2_bridge #(.TIMEOUT(64), .TW(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_be   (cpu_be),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_ack  (cpu_ack),
        .cpu_busy (cpu_busy),
        .cpu_err  (cpu_err),
        .ch2addr  (ch2addr),
        .ch2din   (ch2din),
        .ch2wr    (ch2wr),
        .ch2rd    (ch2rd),
        .ch2dout  (ch2dout),
        .ch2ardy  (ch2ardy),
        .ch2drdy  (ch2drdy)
    );

    always #5 clk = ~clk;

    // one clock; outputs are then sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic request(input logic we, input logic [19:0] addr, input logic [3:0] be,
                           input logic [31:0] din);
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_be   = be;
        cpu_din  = din;
        tick();
        cpu_req  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0;
        cpu_din = '0; ch2dout = '0; ch2ardy = 1'b0; ch2drdy = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(cpu_busy), 32'd0);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_err", 32'(cpu_err), 32'd0);
        chk("rst_dout", cpu_dout, 32'd0);
        chk("rst_ch2addr", 32'(ch2addr), 32'd0);
        chk("rst_ch2wr", 32'(ch2wr), 32'd0);
        chk("rst_ch2rd", 32'(ch2rd), 32'd0);
        reset = 1'b0;
        tick();
        $display("txn reset: checks=%0d errors=%0d", checks, errors);

        // read 0x12345, ardy late, drdy 6 cycles later; a request while busy must be dropped
        ch2dout = 32'hDEADBEEF;
        request(1'b0, 20'h12345, 4'h0, 32'h0);
        chk("rd_busy", 32'(cpu_busy), 32'd1);
        chk("rd_ch2rd", 32'(ch2rd), 32'd1);
        chk("rd_ch2addr", 32'(ch2addr), 32'h2468A);
        chk("rd_ch2wr", 32'(ch2wr), 32'd0);
        tick(); tick();
        chk("rd_ch2rd_hold", 32'(ch2rd), 32'd1);
        ch2ardy = 1'b1;
        tick();
        chk("rd_ch2rd_drop", 32'(ch2rd), 32'd0);
        ch2ardy = 1'b0;
        request(1'b1, 20'h00777, 4'hF, 32'h01020304);
        chk("busy_req_ignored", 32'(ch2wr), 32'd0);
        repeat (4) tick();
        chk("rd_wait_noack", 32'(cpu_ack), 32'd0);
        chk("rd_wait_ch2rd", 32'(ch2rd), 32'd0);
        ch2drdy = 1'b1;
        tick();
        chk("rd_done_noack", 32'(cpu_ack), 32'd0);
        ch2drdy = 1'b0;
        tick();
        chk("rd_ack", 32'(cpu_ack), 32'd1);
        chk("rd_err", 32'(cpu_err), 32'd0);
        chk("rd_dout", cpu_dout, 32'hDEADBEEF);
        chk("rd_busy_ack", 32'(cpu_busy), 32'd1);
        tick();
        chk("rd_ack_single", 32'(cpu_ack), 32'd0);
        chk("rd_busy_low", 32'(cpu_busy), 32'd0);
        chk("busy_req_no_wr", 32'(ch2wr), 32'd0);
        tick();
        chk("busy_req_no_accept", 32'(cpu_busy), 32'd0);
        $display("txn read 0x12345: checks=%0d errors=%0d", checks, errors);

        // full write with ardy held high for 4 cycles
        request(1'b1, 20'h00010, 4'hF, 32'hCAFEF00D);
        chk("wf_hi_addr", 32'(ch2addr), 32'h00020);
        chk("wf_hi_wr", 32'(ch2wr), 32'd3);
        chk("wf_hi_din", 32'(ch2din), 32'hCAFE);
        chk("wf_hi_rd", 32'(ch2rd), 32'd0);
        ch2ardy = 1'b1;
        tick();
        chk("wf_gap_wr", 32'(ch2wr), 32'd0);
        chk("wf_lo_addr", 32'(ch2addr), 32'h00021);
        chk("wf_lo_din", 32'(ch2din), 32'hF00D);
        tick();
        chk("wf_lo_wr", 32'(ch2wr), 32'd3);
        tick();
        chk("wf_lo_wr_held", 32'(ch2wr), 32'd3);
        chk("wf_lo_noack", 32'(cpu_ack), 32'd0);
        ch2ardy = 1'b0;
        tick();
        chk("wf_lo_wr_wait", 32'(ch2wr), 32'd3);
        ch2ardy = 1'b1;
        tick();
        chk("wf_done_wr", 32'(ch2wr), 32'd0);
        chk("wf_done_noack", 32'(cpu_ack), 32'd0);
        ch2ardy = 1'b0;
        tick();
        chk("wf_ack", 32'(cpu_ack), 32'd1);
        chk("wf_err", 32'(cpu_err), 32'd0);
        tick();
        chk("wf_ack_single", 32'(cpu_ack), 32'd0);
        chk("wf_busy_low", 32'(cpu_busy), 32'd0);
        $display("txn write be=F 0x00010: checks=%0d errors=%0d", checks, errors);

        // hi-only write
        request(1'b1, 20'h00ABC, 4'b0100, 32'h11223344);
        chk("whi_wr", 32'(ch2wr), 32'b01);
        chk("whi_addr", 32'(ch2addr), 32'h01578);
        chk("whi_din", 32'(ch2din), 32'h1122);
        ch2ardy = 1'b1;
        tick();
        chk("whi_done_wr", 32'(ch2wr), 32'd0);
        ch2ardy = 1'b0;
        tick();
        chk("whi_ack", 32'(cpu_ack), 32'd1);
        chk("whi_no_lo", 32'(ch2wr), 32'd0);
        tick();
        $display("txn write be=4 0x00ABC: checks=%0d errors=%0d", checks, errors);

        // lo-only write
        request(1'b1, 20'h00ABC, 4'b0010, 32'h55667788);
        chk("wlo_wr", 32'(ch2wr), 32'b10);
        chk("wlo_addr", 32'(ch2addr), 32'h01579);
        chk("wlo_din", 32'(ch2din), 32'h7788);
        ch2ardy = 1'b1;
        tick();
        chk("wlo_done_wr", 32'(ch2wr), 32'd0);
        ch2ardy = 1'b0;
        tick();
        chk("wlo_ack", 32'(cpu_ack), 32'd1);
        tick();
        $display("txn write be=2 0x00ABC: checks=%0d errors=%0d", checks, errors);

        // be=0 write: ack two cycles after accept, no ch2 traffic
        request(1'b1, 20'h00100, 4'h0, 32'hFFFFFFFF);
        chk("wz_busy", 32'(cpu_busy), 32'd1);
        chk("wz_noack", 32'(cpu_ack), 32'd0);
        chk("wz_wr", 32'(ch2wr), 32'd0);
        tick();
        chk("wz_ack", 32'(cpu_ack), 32'd1);
        chk("wz_wr2", 32'(ch2wr), 32'd0);
        chk("wz_rd", 32'(ch2rd), 32'd0);
        tick();
        chk("wz_busy_low", 32'(cpu_busy), 32'd0);
        $display("txn write be=0: checks=%0d errors=%0d", checks, errors);

        // ardy already high when the write starts: no phase advance until a real edge
        ch2ardy = 1'b1;
        tick();
        request(1'b1, 20'h00003, 4'hF, 32'hA5A55A5A);
        chk("wpre_hi_wr", 32'(ch2wr), 32'd3);
        tick();
        chk("wpre_hi_stay_wr", 32'(ch2wr), 32'd3);
        chk("wpre_hi_stay_addr", 32'(ch2addr), 32'h00006);
        ch2ardy = 1'b0;
        tick();
        chk("wpre_hi_stay2", 32'(ch2addr), 32'h00006);
        ch2ardy = 1'b1;
        tick();
        chk("wpre_lo_gap", 32'(ch2wr), 32'd0);
        chk("wpre_lo_addr", 32'(ch2addr), 32'h00007);
        ch2ardy = 1'b0;
        tick();
        chk("wpre_lo_wr", 32'(ch2wr), 32'd3);
        chk("wpre_lo_din", 32'(ch2din), 32'h5A5A);
        ch2ardy = 1'b1;
        tick();
        chk("wpre_done_wr", 32'(ch2wr), 32'd0);
        ch2ardy = 1'b0;
        tick();
        chk("wpre_ack", 32'(cpu_ack), 32'd1);
        tick();
        $display("txn write ardy-preheld: checks=%0d errors=%0d", checks, errors);

        // read with no drdy: RD_WAIT lasts 64 cycles, then DONE, then ack+err
        ch2dout = 32'h12345678;
        request(1'b0, 20'h00001, 4'h0, 32'h0);
        chk("to_ch2rd", 32'(ch2rd), 32'd1);
        ch2ardy = 1'b1;
        tick();
        chk("to_ch2rd_low", 32'(ch2rd), 32'd0);
        ch2ardy = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (cpu_ack) ack_seen++;
        end
        chk("to_no_early_ack", 32'(ack_seen), 32'd0);
        tick();
        chk("to_ack", 32'(cpu_ack), 32'd1);
        chk("to_err", 32'(cpu_err), 32'd1);
        chk("to_dout_kept", cpu_dout, 32'hDEADBEEF);
        chk("to_rd_low", 32'(ch2rd), 32'd0);
        tick();
        chk("to_ack_single", 32'(cpu_ack), 32'd0);
        chk("to_err_single", 32'(cpu_err), 32'd0);
        chk("to_busy_low", 32'(cpu_busy), 32'd0);
        $display("txn read timeout: checks=%0d errors=%0d", checks, errors);

        // zero-wait read after timeout: ack 4 cycles after accept
        ch2dout = 32'h0BADF00D;
        request(1'b0, 20'h00002, 4'h0, 32'h0);
        chk("zr_addr", 32'(ch2addr), 32'h00004);
        ch2ardy = 1'b1;
        tick();
        ch2ardy = 1'b0;
        ch2drdy = 1'b1;
        tick();
        ch2drdy = 1'b0;
        chk("zr_noack", 32'(cpu_ack), 32'd0);
        tick();
        chk("zr_ack", 32'(cpu_ack), 32'd1);
        chk("zr_err", 32'(cpu_err), 32'd0);
        chk("zr_dout", cpu_dout, 32'h0BADF00D);
        tick();
        $display("txn read after timeout: checks=%0d errors=%0d", checks, errors);

        // reset while in WR_LO
        request(1'b1, 20'h00040, 4'hF, 32'h87654321);
        ch2ardy = 1'b1;
        tick();
        ch2ardy = 1'b0;
        tick();
        chk("rw_lo_wr", 32'(ch2wr), 32'd3);
        reset = 1'b1;
        tick();
        chk("rw_wr", 32'(ch2wr), 32'd0);
        chk("rw_busy", 32'(cpu_busy), 32'd0);
        chk("rw_ack", 32'(cpu_ack), 32'd0);
        chk("rw_rd", 32'(ch2rd), 32'd0);
        reset = 1'b0;
        tick();
        chk("rw_idle_ack", 32'(cpu_ack), 32'd0);
        chk("rw_idle_wr", 32'(ch2wr), 32'd0);
        $display("txn reset mid-write: checks=%0d errors=%0d", checks, errors);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
